// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for the segment address unit
package seg_pkg;

  typedef enum logic [1:0] {
    SEG_CS = 2'd0,
    SEG_DS = 2'd1,
    SEG_ES = 2'd2,
    SEG_SS = 2'd3
  } seg_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER0 = 2'd1,
    XFER1 = 2'd2
  } sau_state_t;

  localparam logic [1:0]  BE_LO    = 2'b01;
  localparam logic [1:0]  BE_HI    = 2'b10;
  localparam logic [1:0]  BE_WORD  = 2'b11;
  localparam logic [15:0] CS_RESET = 16'hF000;

endpackage

// File: rtl/seg_phys_adder.sv
// rtl/seg_phys_adder.sv - combinational (seg<<4)+offset; OUT_W beyond the 20-bit window keeps the carry
module seg_phys_adder #(
  parameter int SEG_W = 16,
  parameter int OUT_W = 20
) (
  input  logic [SEG_W-1:0] seg,
  input  logic [SEG_W-1:0] offset,
  output logic [OUT_W-1:0] phys
);

  assign phys = OUT_W'({seg, 4'h0}) + OUT_W'(offset);

endmodule

// File: rtl/segment_address_unit.sv
// rtl/segment_address_unit.sv - segment:offset to physical bus transfers, odd words split in two
// Optional SAU_A20_GATE_EN adds A20_GATE and keeps the adder carry as BUS_ADDR[ADDR_W].
module segment_address_unit
  import seg_pkg::*;
#(
  parameter int SEG_W  = 16,
  parameter int ADDR_W = 20
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [SEG_W-1:0] Q_CS,
  input  logic [SEG_W-1:0] Q_DS,
  input  logic [SEG_W-1:0] Q_ES,
  input  logic [SEG_W-1:0] Q_SS,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [1:0]       REQ_SEG,
  input  logic             REQ_OVR,
  input  logic [1:0]       REQ_OVR_SEG,
  input  logic [SEG_W-1:0] REQ_OFFSET,
  input  logic             REQ_WORD,
  input  logic             REQ_WRITE,
`ifdef SAU_A20_GATE_EN
  input  logic             A20_GATE,
  output logic [ADDR_W:0]  BUS_ADDR,
`else
  output logic [ADDR_W-1:0] BUS_ADDR,
`endif
  output logic             BUS_VALID,
  input  logic             BUS_READY,
  output logic [1:0]       BUS_BE,
  output logic             BUS_WRITE,
  output logic             BUS_LAST
);

`ifdef SAU_A20_GATE_EN
  localparam int OUT_W = ADDR_W + 1;
`else
  localparam int OUT_W = ADDR_W;
`endif

  sau_state_t       state, state_nxt;
  logic             rdy_q;
  logic [SEG_W-1:0] seg_q, off_q, seg_pick, cur_off;
  logic             word_q, write_q;
  logic [OUT_W-1:0] phys, addr_calc;
  logic             accept;

  assign accept    = (state == IDLE) && REQ_VALID && rdy_q;
  assign REQ_READY = rdy_q;

  always_comb begin
    seg_pick = Q_CS;
    unique case (seg_sel_t'(REQ_OVR ? REQ_OVR_SEG : REQ_SEG))
      SEG_CS: seg_pick = Q_CS;
      SEG_DS: seg_pick = Q_DS;
      SEG_ES: seg_pick = Q_ES;
      SEG_SS: seg_pick = Q_SS;
    endcase
  end

  // Second half of a split word stays inside the segment (offset wraps mod 2^SEG_W).
  assign cur_off = (state == XFER1) ? off_q + SEG_W'(1) : off_q;

  seg_phys_adder #(.SEG_W(SEG_W), .OUT_W(OUT_W)) u_adder (
    .seg    (seg_q),
    .offset (cur_off),
    .phys   (phys)
  );

`ifdef SAU_A20_GATE_EN
  logic a20_q;
  assign addr_calc = a20_q ? phys : {1'b0, phys[ADDR_W-1:0]};
`else
  assign addr_calc = phys;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      rdy_q   <= 1'b0;
      seg_q   <= SEG_W'(CS_RESET);
      off_q   <= '0;
      word_q  <= 1'b0;
      write_q <= 1'b0;
`ifdef SAU_A20_GATE_EN
      a20_q   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == IDLE);
      if (accept) begin
        seg_q   <= seg_pick;
        off_q   <= REQ_OFFSET;
        word_q  <= REQ_WORD;
        write_q <= REQ_WRITE;
`ifdef SAU_A20_GATE_EN
        a20_q   <= A20_GATE;
`endif
      end
    end
  end

  always_comb begin
    state_nxt = state;
    BUS_VALID = 1'b0;
    BUS_ADDR  = '0;
    BUS_BE    = 2'b00;
    BUS_WRITE = 1'b0;
    BUS_LAST  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = XFER0;
      end
      XFER0: begin
        BUS_VALID = 1'b1;
        BUS_ADDR  = addr_calc;
        BUS_WRITE = write_q;
        if (!word_q) begin
          BUS_BE   = off_q[0] ? BE_HI : BE_LO;
          BUS_LAST = 1'b1;
        end else if (off_q[0]) begin
          BUS_BE   = BE_HI;
          BUS_LAST = 1'b0;
        end else begin
          BUS_BE   = BE_WORD;
          BUS_LAST = 1'b1;
        end
        if (BUS_READY) state_nxt = BUS_LAST ? IDLE : XFER1;
      end
      XFER1: begin
        BUS_VALID = 1'b1;
        BUS_ADDR  = addr_calc;
        BUS_WRITE = write_q;
        BUS_BE    = BE_LO;
        BUS_LAST  = 1'b1;
        if (BUS_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
